// File: rtl/clarvi_soc_mem_arbiter.sv
// Two-master round-robin arbiter with bounded burst hold in front of one on-chip
// RAM port; a read-tag pipe steers each readdatavalid back to its issuing master.
module clarvi_soc_mem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,

    output logic                err
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                    cur;
    logic [CNT_W-1:0]        cnt;
    logic                    req0, req1, req_cur, req_oth;
    logic                    grant_valid, grant_id;
    logic                    xfer, g_read, g_write;
    logic [READ_LATENCY-1:0] rd_valid, rd_id;
    logic                    err_q;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign req_cur = cur ? req1 : req0;
    assign req_oth = cur ? req0 : req1;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = cur;
        if (req_cur && (!req_oth || cnt < CNT_MAX)) begin
            grant_valid = 1'b1;
        end else if (req_oth) begin
            grant_valid = 1'b1;
            grant_id    = ~cur;
        end
    end

    // A granted master is by construction requesting, so every grant is a transfer.
    assign xfer    = grant_valid & reset_n;
    assign g_read  = grant_id ? m1_read  : m0_read;
    assign g_write = grant_id ? m1_write : m0_write;

    assign mem_address    = (grant_valid && grant_id) ? m1_address    : m0_address;
    assign mem_byteenable = (grant_valid && grant_id) ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = (grant_valid && grant_id) ? m1_writedata  : m0_writedata;
    assign mem_chipselect = xfer;
    assign mem_write      = xfer & g_write;

    assign m0_waitrequest = ~(grant_valid & ~grant_id) | ~reset_n;
    assign m1_waitrequest = ~(grant_valid &  grant_id) | ~reset_n;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values;
    // the tag pipe is reset so responses in flight at reset are dropped (the RAM array needs no reset).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= 1'b0;
            cnt      <= '0;
            rd_valid <= '0;
            rd_id    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (xfer) begin
                if (grant_id == cur) begin
                    if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                end else begin
                    cur <= grant_id;
                    cnt <= CNT_ONE;
                end
                if (g_read && g_write) err_q <= 1'b1;
            end
            // A simultaneous read+write performs only the write.
            rd_valid[0] <= xfer & g_read & ~g_write;
            rd_id[0]    <= grant_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_valid[i] <= rd_valid[i-1];
                rd_id[i]    <= rd_id[i-1];
            end
        end
    end

    assign m0_readdatavalid = rd_valid[READ_LATENCY-1] & ~rd_id[READ_LATENCY-1];
    assign m1_readdatavalid = rd_valid[READ_LATENCY-1] &  rd_id[READ_LATENCY-1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign err              = err_q;

endmodule

// File: tb/tb_clarvi_soc_mem_arbiter.sv
// Bench for clarvi_soc_mem_arbiter: behavioural RAM, directed scenarios, then random
// traffic, all compared against a transaction-level arbitration and memory model.
module tb_clarvi_soc_mem_arbiter;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        d_read, d_write;
    logic [ADDR_W-1:0] d_addr [2];
    logic [3:0]        d_be   [2];
    logic [31:0]       d_wd   [2];

    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, err;
    logic [31:0] mem_writedata, mem_readdata;

    clarvi_soc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(d_addr[0]), .m0_byteenable(d_be[0]), .m0_read(d_read[0]), .m0_write(d_write[0]),
        .m0_writedata(d_wd[0]), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(d_addr[1]), .m1_byteenable(d_be[1]), .m1_read(d_read[1]), .m1_write(d_write[1]),
        .m1_writedata(d_wd[1]), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .err(err)
    );

    function automatic logic [31:0] init_word(input int a);
        if (a == 'h10)   return 32'hDEAD_BEEF;
        if (a == 'h1FFF) return 32'hFFFF_FFFF;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Behavioural RAM, one-cycle read latency; unwritten words read their init pattern.
    logic [31:0] ram     [DEPTH];
    bit          written [DEPTH];
    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_chipselect) begin
            w = written[mem_address] ? ram[mem_address] : init_word(int'(mem_address));
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
                ram[mem_address]     <= w;
                written[mem_address] <= 1'b1;
            end else begin
                mem_readdata <= w;
            end
        end
    end

    // Reference model state
    logic [31:0] shadow [DEPTH];
    logic        owner;
    int          streak;
    bit          pend, exp_err;
    logic        pid;
    logic [31:0] pdata;
    int          glog[$];
    logic [31:0] last_rv_data;
    int          last_rv_id;
    int          total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        d_read = 2'b00; d_write = 2'b00;
    endtask

    // One bus cycle: inputs were driven just after the previous rising edge.
    task automatic cycle();
        bit   gv;
        logic gi, o;
        logic [31:0] w;
        @(negedge clk);
        o  = ~owner;
        gv = 1'b0; gi = owner;
        if ((d_read[owner] | d_write[owner]) && (!(d_read[o] | d_write[o]) || streak < MAX_BURST)) gv = 1'b1;
        else if (d_read[o] | d_write[o]) begin gv = 1'b1; gi = o; end

        check("m0_waitrequest", 32'(m0_waitrequest), 32'(!(gv && gi == 1'b0)));
        check("m1_waitrequest", 32'(m1_waitrequest), 32'(!(gv && gi == 1'b1)));
        check("mem_chipselect", 32'(mem_chipselect), 32'(gv));
        check("mem_write", 32'(mem_write), 32'(gv && d_write[gi]));
        if (gv) begin
            check("mem_address", 32'(mem_address), 32'(d_addr[gi]));
            check("mem_byteenable", 32'(mem_byteenable), 32'(d_be[gi]));
            if (d_write[gi]) check("mem_writedata", mem_writedata, d_wd[gi]);
        end
        check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(pend && pid == 1'b0));
        check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(pend && pid == 1'b1));
        if (pend) begin
            last_rv_data = pid ? m1_readdata : m0_readdata;
            last_rv_id   = int'(pid);
            check("readdata", last_rv_data, pdata);
        end
        check("err", 32'(err), 32'(exp_err));
        glog.push_back(gv ? int'(gi) : -1);

        pend = 1'b0;
        if (gv) begin
            if (gi == owner) streak = (streak < MAX_BURST) ? streak + 1 : MAX_BURST;
            else begin owner = gi; streak = 1; end
            if (d_write[gi]) begin
                w = shadow[d_addr[gi]];
                for (int b = 0; b < 4; b++)
                    if (d_be[gi][b]) w[8*b +: 8] = d_wd[gi][8*b +: 8];
                shadow[d_addr[gi]] = w;
                if (d_read[gi]) exp_err = 1'b1;
            end else begin
                pend = 1'b1; pid = gi; pdata = shadow[d_addr[gi]];
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst m0_waitrequest", 32'(m0_waitrequest), 32'd1);
        check("rst m1_waitrequest", 32'(m1_waitrequest), 32'd1);
        check("rst mem_chipselect", 32'(mem_chipselect), 32'd0);
        check("rst mem_write", 32'(mem_write), 32'd0);
        check("rst m0_readdatavalid", 32'(m0_readdatavalid), 32'd0);
        check("rst m1_readdatavalid", 32'(m1_readdatavalid), 32'd0);
        check("rst err", 32'(err), 32'd0);
        owner = 1'b0; streak = 0; pend = 1'b0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic drive(input int m, input bit rd, input bit wr, input int a,
                         input logic [3:0] be, input logic [31:0] wd);
        d_read[m]  = rd;
        d_write[m] = wr;
        d_addr[m]  = ADDR_W'(a);
        d_be[m]    = be;
        d_wd[m]    = wd;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        set_idle();
        for (int m = 0; m < 2; m++) drive(m, 1'b0, 1'b0, 0, 4'hF, 32'h0);
        #2 do_reset();

        // Single m0 read, m1 idle
        drive(0, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);
        cycle();
        set_idle();
        cycle();
        check("t1 data", last_rv_data, 32'hDEAD_BEEF);
        check("t1 id", 32'(last_rv_id), 32'd0);

        // Continuous contention from reset: m0 x4, m1 x4, m0 x4
        drive(0, 1'b1, 1'b0, 0, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 0, 4'hF, 32'h0);
        do_reset();
        glog.delete();
        for (int i = 0; i < 12; i++) begin
            d_addr[0] = ADDR_W'($urandom);
            d_addr[1] = ADDR_W'($urandom);
            cycle();
        end
        set_idle();
        cycle();
        for (int i = 0; i < 12; i++) check("t2 grant order", 32'(glog[i]), 32'((i / 4) % 2));

        // Partial write then read-back of the same word
        drive(1, 1'b0, 1'b1, 'h1FFF, 4'b0011, 32'hA5A5_A5A5);
        cycle();
        drive(1, 1'b1, 1'b0, 'h1FFF, 4'hF, 32'h0);
        cycle();
        set_idle();
        cycle();
        check("t3 data", last_rv_data, 32'hFFFF_A5A5);
        check("t3 id", 32'(last_rv_id), 32'd1);

        // Alternating single requests with no contention
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            drive(i % 2, 1'b1, 1'b0, 'h20 + i, 4'hF, 32'h0);
            cycle();
            check("t4 cur", 32'(dut.cur), 32'(i % 2));
            check("t4 cnt", 32'(dut.cnt), 32'd1);
        end
        set_idle();
        cycle();

        // Reset while a read response is in flight
        drive(0, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);
        cycle();
        drive(1, 1'b1, 1'b0, 'h11, 4'hF, 32'h0);
        do_reset();
        check("t5 cur", 32'(dut.cur), 32'd0);
        check("t5 cnt", 32'(dut.cnt), 32'd0);
        set_idle();
        repeat (2) cycle();

        // Read+write together: write lands, no response, sticky err
        drive(0, 1'b1, 1'b1, 'h4, 4'hF, 32'h1234_5678);
        cycle();
        set_idle();
        repeat (3) cycle();
        drive(0, 1'b1, 1'b0, 'h4, 4'hF, 32'h0);
        cycle();
        set_idle();
        cycle();
        check("t6 data", last_rv_data, 32'h1234_5678);
        check("t6 err", 32'(err), 32'd1);

        // Random mixed traffic on a small address window to force collisions
        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < 2; m++) begin
                int r;
                r = int'($urandom_range(0, 31));
                drive(m, (r < 12) || (r == 31), (r >= 12 && r < 20) || (r == 31),
                      int'($urandom_range(0, 15)), 4'($urandom), $urandom);
            end
            cycle();
        end
        set_idle();
        cycle();
        do_reset();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
